// File: rtl/readout_rx_pkg.sv
// readout_rx_pkg: scheduler FSM encoding and SDU measurement result constants
package readout_rx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT,
    ST_FINISH,
    ST_WAIT_RES
  } sched_state_t;
  localparam logic MEAS_RESULT_GROUND  = 1'b0;
  localparam logic MEAS_RESULT_EXCITED = 1'b1;
endpackage

// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: combinational round-robin pick over req with a registered start pointer
//   clk, rst_n : clock, synchronous active-low reset (pointer back to 0)
//   req        : request vector
//   en         : allows a grant this cycle
//   update     : commit pointer to granted id + 1 (wrapping)
//   grant, id  : one-hot grant and its encoded index; any = some request granted
module rr_arbiter_param
  import readout_rx_pkg::*;
#(
  parameter int NUM_QUBIT      = 4,
  parameter int QUBIT_ID_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_QUBIT-1:0]      req,
  input  logic                      en,
  input  logic                      update,
  output logic [NUM_QUBIT-1:0]      grant,
  output logic [QUBIT_ID_WIDTH-1:0] id,
  output logic                      any
);
  logic [QUBIT_ID_WIDTH-1:0] ptr, idx;
  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_QUBIT; k++) begin
      idx = QUBIT_ID_WIDTH'((int'(ptr) + k) % NUM_QUBIT);
      if (en && !any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (update) ptr <= (id == QUBIT_ID_WIDTH'(NUM_QUBIT - 1)) ? '0 : id + 1'b1;
endmodule

// File: rtl/readout_rx_meas_window_scheduler.sv
// readout_rx_meas_window_scheduler: shares one state-decision unit among qubit requesters
//   clk, rst_n                    : clock, synchronous active-low reset
//   req_in / grant_out            : level requests, one-hot grant pulse
//   sample_*_in                   : demodulated I/Q stream
//   sdu_start/finish_count_out    : SDU arm and end-of-window pulses
//   sdu_valid/i/q_out             : registered, window-gated samples to the SDU
//   sdu_valid_meas_result_in, sdu_meas_result_in : SDU decision
//   result_*_out                  : one-cycle tagged result (timeout flagged)
//   busy_out                      : high outside IDLE
module readout_rx_meas_window_scheduler
  import readout_rx_pkg::*;
#(
  parameter int NUM_QUBIT      = 4,
  parameter int QUBIT_ID_WIDTH = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int WINDOW_LEN     = 1024,
  parameter int WIN_CNT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 70000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_QUBIT-1:0]      req_in,
  output logic [NUM_QUBIT-1:0]      grant_out,
  input  logic                      sample_valid_in,
  input  logic [DATA_WIDTH-1:0]     sample_i_in,
  input  logic [DATA_WIDTH-1:0]     sample_q_in,
  output logic                      sdu_start_count_out,
  output logic                      sdu_finish_count_out,
  output logic                      sdu_valid_out,
  output logic [DATA_WIDTH-1:0]     sdu_i_out,
  output logic [DATA_WIDTH-1:0]     sdu_q_out,
  input  logic                      sdu_valid_meas_result_in,
  input  logic                      sdu_meas_result_in,
  output logic                      result_valid_out,
  output logic [QUBIT_ID_WIDTH-1:0] result_qubit_id_out,
  output logic                      result_out,
  output logic                      result_timeout_out,
  output logic                      busy_out
);
  sched_state_t              state, state_nxt;
  logic [QUBIT_ID_WIDTH-1:0] id_q, arb_id;
  logic [WIN_CNT_WIDTH-1:0]  win_cnt;
  logic [TIMEOUT_WIDTH-1:0]  tmo_cnt;
  logic                      arb_en, arb_any, take, last, tmo_hit;
  logic                      res_fire, res_bit, res_tmo;
  // The result cycle itself is kept free of grants so windows are separated by an idle cycle.
  assign arb_en  = rst_n && state == ST_IDLE && !result_valid_out;
  assign take    = state == ST_COUNT && sample_valid_in;
  assign last    = take && win_cnt == WIN_CNT_WIDTH'(WINDOW_LEN - 1);
  // The timeout counter already runs during FINISH, so the deadline lands TIMEOUT_CYCLES after the finish pulse.
  assign tmo_hit = tmo_cnt >= TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  assign sdu_start_count_out  = state == ST_ARM;
  assign sdu_finish_count_out = state == ST_FINISH;
  assign busy_out             = state != ST_IDLE;
  rr_arbiter_param #(
    .NUM_QUBIT     (NUM_QUBIT),
    .QUBIT_ID_WIDTH(QUBIT_ID_WIDTH)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_in),
    .en    (arb_en),
    .update(arb_any),
    .grant (grant_out),
    .id    (arb_id),
    .any   (arb_any)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? ST_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    res_fire  = 1'b0;
    res_bit   = MEAS_RESULT_GROUND;
    res_tmo   = 1'b0;
    case (state)
      ST_IDLE:   state_nxt = arb_any ? ST_ARM : ST_IDLE;
      ST_ARM:    state_nxt = ST_COUNT;
      ST_COUNT:  state_nxt = last ? ST_FINISH : ST_COUNT;
      ST_FINISH: state_nxt = ST_WAIT_RES;
      ST_WAIT_RES: begin
        res_fire  = sdu_valid_meas_result_in || tmo_hit;
        res_bit   = sdu_valid_meas_result_in ? sdu_meas_result_in : MEAS_RESULT_GROUND;
        res_tmo   = !sdu_valid_meas_result_in && tmo_hit;
        state_nxt = res_fire ? ST_IDLE : ST_WAIT_RES;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      id_q                <= '0;
      win_cnt             <= '0;
      tmo_cnt             <= '0;
      sdu_valid_out       <= 1'b0;
      sdu_i_out           <= '0;
      sdu_q_out           <= '0;
      result_valid_out    <= 1'b0;
      result_qubit_id_out <= '0;
      result_out          <= 1'b0;
      result_timeout_out  <= 1'b0;
    end else begin
      id_q                <= arb_any ? arb_id : id_q;
      win_cnt             <= state == ST_ARM ? '0 : take ? win_cnt + 1'b1 : win_cnt;
      tmo_cnt             <= (state == ST_FINISH || state == ST_WAIT_RES) ? tmo_cnt + 1'b1 : '0;
      sdu_valid_out       <= take;
      sdu_i_out           <= take ? sample_i_in : sdu_i_out;
      sdu_q_out           <= take ? sample_q_in : sdu_q_out;
      result_valid_out    <= res_fire;
      result_qubit_id_out <= res_fire ? id_q : '0;
      result_out          <= res_fire && res_bit;
      result_timeout_out  <= res_tmo;
    end
endmodule
